// File: rtl/uart_16550_tx.sv
// uart_16550_tx: 16550-compatible transmit path with TX FIFO, 16x baud generator and frame serialiser
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   divisor           16x tick every divisor clk cycles; 0 stops the baud clock
//   thr_wr, thr_data  THR write strobe and byte
//   fifo_en           FCR[0]; 0 limits the FIFO to a single holding register
//   tx_fifo_clr       FCR[2] pulse; flushes queued bytes
//   word_len, stop_bits, parity_en, even_parity, stick_parity, set_break  LCR fields
//   txd               serial output, idle high
//   thre, temt        holding register empty, transmitter empty
//   tx_level          FIFO occupancy
module uart_16550_tx #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIV_W-1:0]              divisor,
  input  logic                          thr_wr,
  input  logic [7:0]                    thr_data,
  input  logic                          fifo_en,
  input  logic                          tx_fifo_clr,
  input  logic [1:0]                    word_len,
  input  logic                          stop_bits,
  input  logic                          parity_en,
  input  logic                          even_parity,
  input  logic                          stick_parity,
  input  logic                          set_break,
  output logic                          txd,
  output logic                          thre,
  output logic                          temt,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} stateT;
  stateT state;
  logic [DIV_W-1:0] baudCnt;
  logic tick;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rdPtr, wrPtr;
  logic fifoEnQ, flush, full, push, pop, stopEnd, idleNext;
  logic [LW-1:0] levelNext;
  logic [7:0] head, dataMask;
  logic headParity;
  logic [4:0] tickCnt, stopLast;
  logic [2:0] bitCnt, lastBit;
  logic [7:0] shReg;
  logic parityEn, parityBit, txdReg;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) baudCnt <= '0;
    else baudCnt <= (divisor == '0) ? '0 : (baudCnt == '0) ? divisor - DIV_W'(1) : baudCnt - DIV_W'(1);
  assign tick = (divisor != '0) && (baudCnt == '0);
  // toggling fifo_en flushes the queue just like an explicit clear
  assign flush = tx_fifo_clr || (fifo_en != fifoEnQ);
  assign full = tx_level >= (fifo_en ? LW'(FIFO_DEPTH) : LW'(1));
  assign push = thr_wr && !full && !flush;
  assign stopEnd = tick && (tickCnt == stopLast);
  // a pop happens from IDLE on any tick, or at the final stop tick for back-to-back frames
  assign pop = (tx_level != '0) && tick && (state == IDLE || (state == STOP && tickCnt == stopLast));
  assign levelNext = flush ? '0 : tx_level + LW'(push) - LW'(pop);
  assign idleNext = !pop && (state == IDLE || (state == STOP && stopEnd));
  assign head = mem[rdPtr];
  assign dataMask = 8'hFF >> (2'd3 - word_len);
  assign headParity = stick_parity ? ~even_parity : (^(head & dataMask)) ^ ~even_parity;
  assign txd = txdReg & ~set_break;
  always_ff @(posedge clk)
    if (push) mem[wrPtr] <= thr_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_level <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
      fifoEnQ <= 1'b0;
    end else begin
      tx_level <= levelNext;
      fifoEnQ <= fifo_en;
      rdPtr <= flush ? '0 : rdPtr + AW'(pop);
      wrPtr <= flush ? '0 : wrPtr + AW'(push);
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      txdReg <= 1'b1;
      tickCnt <= '0;
      bitCnt <= '0;
      lastBit <= '0;
      stopLast <= '0;
      shReg <= '0;
      parityEn <= 1'b0;
      parityBit <= 1'b0;
      thre <= 1'b1;
      temt <= 1'b1;
    end else begin
      thre <= levelNext == '0;
      temt <= (levelNext == '0) && idleNext;
      if (pop) begin
        state <= START;
        txdReg <= 1'b0;
        tickCnt <= '0;
        bitCnt <= '0;
        shReg <= head;
        lastBit <= 3'd4 + 3'(word_len);
        parityEn <= parity_en;
        parityBit <= headParity;
        stopLast <= !stop_bits ? 5'd15 : (word_len == 2'd0) ? 5'd23 : 5'd31;
      end else if (tick) begin
        tickCnt <= (state == IDLE) || (state == STOP ? tickCnt == stopLast : tickCnt == 5'd15) ? '0 : tickCnt + 5'd1;
        case (state)
          START:
            if (tickCnt == 5'd15) begin
              state <= DATA;
              txdReg <= shReg[0];
              shReg <= shReg >> 1;
            end
          DATA:
            if (tickCnt == 5'd15) begin
              if (bitCnt == lastBit) begin
                state <= parityEn ? PARITY : STOP;
                txdReg <= parityEn ? parityBit : 1'b1;
              end else begin
                bitCnt <= bitCnt + 3'd1;
                txdReg <= shReg[0];
                shReg <= shReg >> 1;
              end
            end
          PARITY:
            if (tickCnt == 5'd15) begin
              state <= STOP;
              txdReg <= 1'b1;
            end
          STOP:
            if (tickCnt == stopLast) state <= IDLE;
          default: ;
        endcase
      end
    end
endmodule
